// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions for the storage read/write ECC path.
package hamming_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned CODE_W        = 12;
  localparam int unsigned SYN_W         = 4;
  localparam int unsigned SYN_MAX_VALID = 12;

  typedef logic [CODE_W-1:0] codeword_t;
  typedef logic [SYN_W-1:0]  syndrome_t;
  typedef logic [DATA_W-1:0] data_t;

  // Syndrome bit k covers every codeword bit whose Hamming position (index+1) has bit k set.
  function automatic syndrome_t calc_syndrome(input codeword_t cw);
    syndrome_t syn;
    syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10];
    syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10];
    syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6] ^ cw[11];
    syn[3] = cw[7] ^ cw[8] ^ cw[9] ^ cw[10] ^ cw[11];
    return syn;
  endfunction

  // Write-side parity {P4,P3,P2,P1} for a data byte; shared with the encoder.
  function automatic logic [3:0] calc_parity(input data_t d);
    logic [3:0] p;
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return p;
  endfunction

  // Pull the data byte out of its non-power-of-two positions.
  function automatic data_t extract_data(input codeword_t cw);
    return {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
  endfunction

endpackage

// File: rtl/hamming_sat_counter.sv
// Saturating event counter with synchronous clear that overrides increment.
module hamming_sat_counter #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] CountMax = '1;

  logic [COUNT_W-1:0] count_d, count_q;

  // Next count: clear first, otherwise increment until the ceiling.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CountMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage Hamming(12,8) read-path decoder: single-bit correction, uncorrectable flagging
// and saturating error-event counters for RAID health monitoring.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        enc_data_in,
  input  logic               enc_data_valid_in,
  input  logic [ADDR_W-1:0]  address_in,
  input  logic               clear_counts,
  output logic [7:0]         data_out,
  output logic [ADDR_W-1:0]  address_out,
  output logic               data_valid_out,
  output logic [3:0]         syndrome_out,
  output logic               err_corrected,
  output logic               err_uncorrectable,
  output logic [COUNT_W-1:0] corrected_count,
  output logic [COUNT_W-1:0] uncorrectable_count
);

  // Stage 1 state
  logic              valid1_d, valid1_q;
  codeword_t         code1_d, code1_q;
  logic [ADDR_W-1:0] addr1_d, addr1_q;
  syndrome_t         syn1_d, syn1_q;

  // Stage 2 state (drives the outputs)
  logic              valid2_d, valid2_q;
  data_t             data2_d, data2_q;
  logic [ADDR_W-1:0] addr2_d, addr2_q;
  syndrome_t         syn2_d, syn2_q;
  logic              corr2_d, corr2_q;
  logic              unc2_d, unc2_q;

  codeword_t         fixed;

  // Stage 1: capture the word and its syndrome; idle slots carry all-zero payload.
  always_comb begin
    valid1_d = enc_data_valid_in;
    code1_d  = '0;
    addr1_d  = '0;
    syn1_d   = '0;
    if (enc_data_valid_in) begin
      code1_d = enc_data_in;
      addr1_d = address_in;
      syn1_d  = calc_syndrome(enc_data_in);
    end
  end

  // Stage 2: flip the bit the syndrome points at, classify and extract data.
  always_comb begin
    fixed    = code1_q;
    valid2_d = valid1_q;
    data2_d  = '0;
    addr2_d  = '0;
    syn2_d   = '0;
    corr2_d  = 1'b0;
    unc2_d   = 1'b0;
    // Syndromes 13..15 match no index here, so those words pass through unflipped.
    for (int i = 0; i < CODE_W; i++) begin
      if (syn1_q == syndrome_t'(i + 1)) begin
        fixed[i] = ~code1_q[i];
      end
    end
    if (valid1_q) begin
      data2_d = extract_data(fixed);
      addr2_d = addr1_q;
      syn2_d  = syn1_q;
      corr2_d = (syn1_q != '0) && (syn1_q <= syndrome_t'(SYN_MAX_VALID));
      unc2_d  = (syn1_q > syndrome_t'(SYN_MAX_VALID));
    end
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1_q <= 1'b0;
      code1_q  <= '0;
      addr1_q  <= '0;
      syn1_q   <= '0;
      valid2_q <= 1'b0;
      data2_q  <= '0;
      addr2_q  <= '0;
      syn2_q   <= '0;
      corr2_q  <= 1'b0;
      unc2_q   <= 1'b0;
    end else begin
      valid1_q <= valid1_d;
      code1_q  <= code1_d;
      addr1_q  <= addr1_d;
      syn1_q   <= syn1_d;
      valid2_q <= valid2_d;
      data2_q  <= data2_d;
      addr2_q  <= addr2_d;
      syn2_q   <= syn2_d;
      corr2_q  <= corr2_d;
      unc2_q   <= unc2_d;
    end
  end

  // Counters take the stage-2 next-state flags so each count updates with its flag.
  hamming_sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_corr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (corr2_d),
    .clr   (clear_counts),
    .count (corrected_count)
  );

  hamming_sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_unc_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (unc2_d),
    .clr   (clear_counts),
    .count (uncorrectable_count)
  );

  assign data_out          = data2_q;
  assign address_out       = addr2_q;
  assign data_valid_out    = valid2_q;
  assign syndrome_out      = syn2_q;
  assign err_corrected     = corr2_q;
  assign err_uncorrectable = unc2_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: a 16-bit-counter instance for datapath checks and a
// 2-bit-counter instance sharing the same stimulus for saturation checks.
module tb_hamming_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] enc_data_in;
  logic        enc_data_valid_in;
  logic [7:0]  address_in;
  logic        clear_counts;

  logic [7:0]  data_out, s_data_out;
  logic [7:0]  address_out, s_address_out;
  logic        data_valid_out, s_data_valid_out;
  logic [3:0]  syndrome_out, s_syndrome_out;
  logic        err_corrected, s_err_corrected;
  logic        err_uncorrectable, s_err_uncorrectable;
  logic [15:0] corrected_count, uncorrectable_count;
  logic [1:0]  s_corrected_count, s_uncorrectable_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_decoder #(
    .ADDR_W  (8),
    .COUNT_W (16)
  ) u_dut (
    .clk                 (clk),
    .reset               (reset),
    .enc_data_in         (enc_data_in),
    .enc_data_valid_in   (enc_data_valid_in),
    .address_in          (address_in),
    .clear_counts        (clear_counts),
    .data_out            (data_out),
    .address_out         (address_out),
    .data_valid_out      (data_valid_out),
    .syndrome_out        (syndrome_out),
    .err_corrected       (err_corrected),
    .err_uncorrectable   (err_uncorrectable),
    .corrected_count     (corrected_count),
    .uncorrectable_count (uncorrectable_count)
  );

  hamming_decoder #(
    .ADDR_W  (8),
    .COUNT_W (2)
  ) u_sat (
    .clk                 (clk),
    .reset               (reset),
    .enc_data_in         (enc_data_in),
    .enc_data_valid_in   (enc_data_valid_in),
    .address_in          (address_in),
    .clear_counts        (clear_counts),
    .data_out            (s_data_out),
    .address_out         (s_address_out),
    .data_valid_out      (s_data_valid_out),
    .syndrome_out        (s_syndrome_out),
    .err_corrected       (s_err_corrected),
    .err_uncorrectable   (s_err_uncorrectable),
    .corrected_count     (s_corrected_count),
    .uncorrectable_count (s_uncorrectable_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one slot at the negedge and return at the next negedge (one posedge later).
  task automatic apply(input logic v, input logic [11:0] cw, input logic [7:0] a,
                       input logic clr);
    enc_data_valid_in = v;
    enc_data_in       = cw;
    address_in        = a;
    clear_counts      = clr;
    @(negedge clk);
  endtask

  task automatic chk_word(input string tag, input logic [7:0] d, input logic [7:0] a,
                          input logic [3:0] syn, input logic c, input logic u);
    chk({tag, "_valid"}, 32'(data_valid_out), 32'd1);
    chk({tag, "_data"}, 32'(data_out), 32'(d));
    chk({tag, "_addr"}, 32'(address_out), 32'(a));
    chk({tag, "_syn"}, 32'(syndrome_out), 32'(syn));
    chk({tag, "_corr"}, 32'(err_corrected), 32'(c));
    chk({tag, "_unc"}, 32'(err_uncorrectable), 32'(u));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(data_valid_out), 32'd0);
    chk({tag, "_data"}, 32'(data_out), 32'd0);
    chk({tag, "_addr"}, 32'(address_out), 32'd0);
    chk({tag, "_syn"}, 32'(syndrome_out), 32'd0);
    chk({tag, "_flags"}, 32'({err_corrected, err_uncorrectable}), 32'd0);
  endtask

  logic pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    reset             = 1'b1;
    enc_data_in       = '0;
    enc_data_valid_in = 1'b0;
    address_in        = '0;
    clear_counts      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("por");
    chk("por_ccnt", 32'(corrected_count), 32'd0);
    chk("por_ucnt", 32'(uncorrectable_count), 32'd0);
    reset = 1'b0;

    // Reset mid-stream with words in both stages
    apply(1'b1, 12'hA27, 8'h3C, 1'b0);
    apply(1'b1, 12'hA07, 8'h44, 1'b0);
    chk("pre_rst_valid", 32'(data_valid_out), 32'd1);
    enc_data_valid_in = 1'b0;
    reset = 1'b1;
    #1;
    chk_idle("midrst");
    chk("midrst_ccnt", 32'(corrected_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 12'h000, 8'h00, 1'b0);
      chk("post_rst_valid", 32'(data_valid_out), 32'd0);
    end

    // Clean word
    apply(1'b1, 12'hA27, 8'h3C, 1'b0);
    apply(1'b0, 12'h000, 8'h00, 1'b0);
    chk_word("clean", 8'hA5, 8'h3C, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 12'h000, 8'h00, 1'b0);
    chk_idle("gap");

    // Data bit d2 flipped
    apply(1'b1, 12'hA07, 8'h11, 1'b0);
    apply(1'b0, 12'h000, 8'h00, 1'b0);
    chk_word("d2err", 8'hA5, 8'h11, 4'd6, 1'b1, 1'b0);
    chk("d2err_ccnt", 32'(corrected_count), 32'd1);

    // Parity bit P4 flipped
    apply(1'b1, 12'hAA7, 8'h22, 1'b0);
    apply(1'b0, 12'h000, 8'h00, 1'b0);
    chk_word("p4err", 8'hA5, 8'h22, 4'd8, 1'b1, 1'b0);
    chk("p4err_ccnt", 32'(corrected_count), 32'd2);

    // Double error landing on syndrome 13
    apply(1'b1, 12'h226, 8'h33, 1'b0);
    apply(1'b0, 12'h000, 8'h00, 1'b0);
    chk_word("dbl", 8'h25, 8'h33, 4'd13, 1'b0, 1'b1);
    chk("dbl_ucnt", 32'(uncorrectable_count), 32'd1);
    chk("dbl_ccnt", 32'(corrected_count), 32'd2);

    // Highest correctable position (bit 11 / d7)
    apply(1'b1, 12'h227, 8'h77, 1'b0);
    apply(1'b0, 12'h000, 8'h00, 1'b0);
    chk_word("b11err", 8'hA5, 8'h77, 4'd12, 1'b1, 1'b0);
    chk("b11_ccnt", 32'(corrected_count), 32'd3);

    // Clear, then saturate the 2-bit counter
    apply(1'b0, 12'h000, 8'h00, 1'b1);
    chk("clr_ccnt", 32'(corrected_count), 32'd0);
    chk("clr_ucnt", 32'(uncorrectable_count), 32'd0);
    chk("clr_sat_ccnt", 32'(s_corrected_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 12'hA07, 8'(8'h60 + i), 1'b0);
    end
    apply(1'b0, 12'h000, 8'h00, 1'b0);
    apply(1'b0, 12'h000, 8'h00, 1'b0);
    chk("sat_ccnt", 32'(s_corrected_count), 32'd3);
    chk("wide_ccnt", 32'(corrected_count), 32'd5);
    apply(1'b1, 12'hA07, 8'h70, 1'b0);
    apply(1'b0, 12'h000, 8'h00, 1'b0);
    chk("sat_hold_corr", 32'(s_err_corrected), 32'd1);
    chk("sat_hold_ccnt", 32'(s_corrected_count), 32'd3);
    chk("wide6_ccnt", 32'(corrected_count), 32'd6);

    // Clear coincident with the increment edge
    apply(1'b1, 12'hA07, 8'h71, 1'b0);
    apply(1'b0, 12'h000, 8'h00, 1'b1);
    chk("clrwin_corr", 32'(err_corrected), 32'd1);
    chk("clrwin_sat_ccnt", 32'(s_corrected_count), 32'd0);
    chk("clrwin_ccnt", 32'(corrected_count), 32'd0);
    apply(1'b0, 12'h000, 8'h00, 1'b0);
    chk("clrwin_after", 32'(corrected_count), 32'd0);

    // Valid/invalid alternation reproduced at the output
    for (int i = 0; i < 8; i++) begin
      apply(pat[i], 12'hA27, 8'(8'h50 + i), 1'b0);
      if (i >= 1) begin
        chk("alt_valid", 32'(data_valid_out), 32'(pat[i-1]));
        chk("alt_addr", 32'(address_out), pat[i-1] ? 32'(8'h4F + i) : 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
